ecc_decode: RTL and testbench

- SEC-DED check/correct stage on the FIFO read path, directly downstream of the write-side ECC encoder.
- Takes each 32-bit data word plus its stored check bits as read from FIFO memory. Recomputes the syndrome, corrects single-bit errors and flags double-bit errors.
- Delivers the corrected word through a 2-stage valid/ready pipeline and keeps saturating error counters for status readout.

---
 rtl/ecc_pkg.sv | 61 ++++++
 rtl/ecc_syndrome.sv | 19 +
 rtl/ecc_decode.sv | 129 ++++++++++++
 tb/tb_ecc_decode.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared (39,32) extended-Hamming code definition for the FIFO ECC path.
// Both the write-side encoder and the read-side decoder take the code from here.
package ecc_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ECC_WIDTH  = 7;
   localparam int SYN_WIDTH  = 6;

   // Codeword position of each data bit: the positions in 1..38 that are not powers of two.
   localparam logic [SYN_WIDTH-1:0] POS [DATA_WIDTH] = '{
      6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
      6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
      6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
      6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
   };

   // Highest codeword position; syndromes above this cannot come from a single error.
   localparam logic [SYN_WIDTH-1:0] MAX_POS = 6'd38;

   typedef struct packed {
      logic       hit;   // syndrome names a data-bit position
      logic [4:0] idx;   // which data bit
   } syn_lkp_t;

   typedef enum logic [1:0] {
      DEC_CLEAN,     // no error
      DEC_SBE_CHK,   // single error in a check or parity bit, data already good
      DEC_SBE_DATA,  // single error in a data bit, flip it
      DEC_DBE        // uncorrectable
   } dec_kind_t;

   // Hamming check bits [5:0] only.
   function automatic logic [SYN_WIDTH-1:0] ham_gen(input logic [DATA_WIDTH-1:0] d);
      logic [SYN_WIDTH-1:0] h;
      h = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         for (int k = 0; k < SYN_WIDTH; k++)
            if (POS[i][k]) h[k] = h[k] ^ d[i];
      return h;
   endfunction

   // Full check word: Hamming bits plus even overall parity in bit 6.
   function automatic logic [ECC_WIDTH-1:0] ecc_gen(input logic [DATA_WIDTH-1:0] d);
      logic [SYN_WIDTH-1:0] h;
      h = ham_gen(d);
      return {(^d) ^ (^h), h};
   endfunction

   // Map a syndrome back to the data bit it points at, if any.
   function automatic syn_lkp_t syn_lookup(input logic [SYN_WIDTH-1:0] s);
      syn_lkp_t r;
      r = '{hit: 1'b0, idx: 5'd0};
      for (int i = 0; i < DATA_WIDTH; i++)
         if (POS[i] == s) begin
            r.hit = 1'b1;
            r.idx = 5'(i);
         end
      return r;
   endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational syndrome and overall-parity generator for one received codeword.
module ecc_syndrome (
   input  logic [ecc_pkg::DATA_WIDTH-1:0] i_data,
   input  logic [ecc_pkg::ECC_WIDTH-1:0]  i_chk,
   output logic [ecc_pkg::SYN_WIDTH-1:0]  o_syn,
   output logic                           o_par
);
   import ecc_pkg::*;

   logic [SYN_WIDTH-1:0] w_ham;

   // Syndrome is recomputed Hamming vs stored; parity spans all 39 received bits.
   always_comb begin
      w_ham = ham_gen(i_data);
      o_syn = w_ham ^ i_chk[SYN_WIDTH-1:0];
      o_par = (^i_data) ^ (^i_chk);
   end

endmodule

// File: rtl/ecc_decode.sv
// SEC-DED check/correct stage on the FIFO read path: two-stage valid/ready
// pipeline (capture + syndrome, then decode/correct) with saturating error counters.
module ecc_decode #(
   parameter int DATA_WIDTH = 32,
   parameter int ECC_WIDTH  = 7,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  In_valid,
   output logic                  In_ready,
   input  logic [DATA_WIDTH-1:0] DataIn,
   input  logic [ECC_WIDTH-1:0]  ChkIn,
   output logic                  Out_valid,
   input  logic                  Out_ready,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic                  Sbe,
   output logic                  Dbe,
   input  logic                  Cnt_clr,
   output logic [CNT_WIDTH-1:0]  SbeCount,
   output logic [CNT_WIDTH-1:0]  DbeCount
);
   import ecc_pkg::*;

   logic                  w_adv;
   logic                  w_hs;

   logic                  r_s1_vld;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic [ECC_WIDTH-1:0]  r_s1_chk;

   logic [SYN_WIDTH-1:0]  w_syn;
   logic                  w_par;
   syn_lkp_t              w_lkp;
   dec_kind_t             w_kind;
   logic [DATA_WIDTH-1:0] w_fix;

   logic                  r_out_vld;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_sbe;
   logic                  r_dbe;
   logic [CNT_WIDTH-1:0]  r_sbe_cnt;
   logic [CNT_WIDTH-1:0]  r_dbe_cnt;

   // Whole pipe advances together whenever the output slot is free or draining.
   assign w_adv     = Out_ready | ~r_out_vld;
   assign w_hs      = r_out_vld & Out_ready;
   assign In_ready  = w_adv;
   assign Out_valid = r_out_vld;
   assign DataOut   = r_out_data;
   assign Sbe       = r_sbe;
   assign Dbe       = r_dbe;
   assign SbeCount  = r_sbe_cnt;
   assign DbeCount  = r_dbe_cnt;

   // Stage 1: capture the raw word and its check bits.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_s1_vld  <= 1'b0;
         r_s1_data <= '0;
         r_s1_chk  <= '0;
      end else if (w_adv) begin
         r_s1_vld <= In_valid;
         if (In_valid) begin
            r_s1_data <= DataIn;
            r_s1_chk  <= ChkIn;
         end
      end
   end

   ecc_syndrome u_syn (
      .i_data (r_s1_data),
      .i_chk  (r_s1_chk),
      .o_syn  (w_syn),
      .o_par  (w_par)
   );

   // Classify the syndrome/parity pair and build the corrected word.
   always_comb begin
      w_lkp  = syn_lookup(w_syn);
      w_kind = DEC_CLEAN;
      w_fix  = r_s1_data;
      if (w_par) begin
         if (w_lkp.hit) begin
            w_kind = DEC_SBE_DATA;
            w_fix  = r_s1_data ^ (DATA_WIDTH'(1) << w_lkp.idx);
         end else if (w_syn <= MAX_POS) begin
            // syndrome 0 (parity bit) or a power of two (check bit)
            w_kind = DEC_SBE_CHK;
         end else begin
            w_kind = DEC_DBE;
         end
      end else if (w_syn != '0) begin
         w_kind = DEC_DBE;
      end
   end

   // Stage 2: output register; flags are cleared whenever no word is presented.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_sbe      <= 1'b0;
         r_dbe      <= 1'b0;
      end else if (w_adv) begin
         r_out_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_out_data <= w_fix;
            r_sbe      <= (w_kind == DEC_SBE_DATA) || (w_kind == DEC_SBE_CHK);
            r_dbe      <= (w_kind == DEC_DBE);
         end else begin
            r_sbe <= 1'b0;
            r_dbe <= 1'b0;
         end
      end
   end

   // Error counters: count once per delivered word, saturate, clear has priority.
   always_ff @(posedge Clock) begin
      if (Reset || Cnt_clr) begin
         r_sbe_cnt <= '0;
         r_dbe_cnt <= '0;
      end else if (w_hs) begin
         if (r_sbe && (r_sbe_cnt != '1)) r_sbe_cnt <= r_sbe_cnt + 1'b1;
         if (r_dbe && (r_dbe_cnt != '1)) r_dbe_cnt <= r_dbe_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_decode.sv
// Directed bench for ecc_decode: vector table plus backpressure, saturation,
// clear and reset sequences.
module tb_ecc_decode;

   logic        Clock = 1'b0;
   logic        Reset, In_valid, Out_ready, Cnt_clr;
   logic        In_ready, Out_valid, Sbe, Dbe;
   logic [31:0] DataIn, DataOut;
   logic [6:0]  ChkIn;
   logic [15:0] SbeCount, DbeCount;

   ecc_decode dut (
      .Clock(Clock), .Reset(Reset), .In_valid(In_valid), .In_ready(In_ready),
      .DataIn(DataIn), .ChkIn(ChkIn), .Out_valid(Out_valid), .Out_ready(Out_ready),
      .DataOut(DataOut), .Sbe(Sbe), .Dbe(Dbe), .Cnt_clr(Cnt_clr),
      .SbeCount(SbeCount), .DbeCount(DbeCount)
   );

   always #5 Clock = ~Clock;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Independent encoder: walk codeword positions, skipping powers of two.
   function automatic logic [6:0] tb_enc(input logic [31:0] d);
      int p;
      logic [5:0] h;
      p = 0;
      h = '0;
      for (int i = 0; i < 32; i++) begin
         p++;
         while ((p & (p - 1)) == 0) p++;
         for (int k = 0; k < 6; k++)
            if (((p >> k) & 1) == 1) h[k] = h[k] ^ d[i];
      end
      return {(^d) ^ (^h), h};
   endfunction

   typedef struct {
      string       name;
      logic [31:0] din;
      logic [6:0]  chk;
      logic [31:0] dout;
      logic        sbe;
      logic        dbe;
   } vec_t;

   vec_t vt[10];

   task automatic send_one(input logic [31:0] d, input logic [6:0] c);
      In_valid = 1'b1;
      DataIn   = d;
      ChkIn    = c;
      @(posedge Clock); #1;
      In_valid = 1'b0;
      @(posedge Clock); #1;
   endtask

   initial begin
      int exp_sc, exp_dc;
      logic [31:0] w [4];
      int tx, rx, stall_left;
      bit started, in_hs, out_hs;

      vt[0] = '{"clean_deadbeef", 32'hDEADBEEF, tb_enc(32'hDEADBEEF), 32'hDEADBEEF, 1'b0, 1'b0};
      vt[1] = '{"data_bit0",      32'h00000001, tb_enc(32'h0),        32'h00000000, 1'b1, 1'b0};
      vt[2] = '{"chk_bit2",       32'h12345678, tb_enc(32'h12345678) ^ 7'h04, 32'h12345678, 1'b1, 1'b0};
      vt[3] = '{"parity_bit6",    32'h12345678, tb_enc(32'h12345678) ^ 7'h40, 32'h12345678, 1'b1, 1'b0};
      vt[4] = '{"double_err",     32'h00000003, tb_enc(32'h0),        32'h00000003, 1'b0, 1'b1};
      vt[5] = '{"data_bit31",     32'h80000000, tb_enc(32'h0),        32'h00000000, 1'b1, 1'b0};
      vt[6] = '{"syn_over_38",    32'hCAFEF00D, tb_enc(32'hCAFEF00D) ^ 7'h7F, 32'hCAFEF00D, 1'b0, 1'b1};
      vt[7] = '{"clean_ones",     32'hFFFFFFFF, tb_enc(32'hFFFFFFFF), 32'hFFFFFFFF, 1'b0, 1'b0};
      vt[8] = '{"data_bit16",     32'h00010000, tb_enc(32'h0),        32'h00000000, 1'b1, 1'b0};
      vt[9] = '{"chk_bit0",       32'h00000000, 7'h01,                32'h00000000, 1'b1, 1'b0};

      Reset = 1'b1; In_valid = 1'b0; Out_ready = 1'b1; Cnt_clr = 1'b0;
      DataIn = '0; ChkIn = '0;
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      check("rst_out_valid", Out_valid, 0);
      check("rst_sbe",       Sbe, 0);
      check("rst_dbe",       Dbe, 0);
      check("rst_dataout",   DataOut, 0);
      check("rst_sbecount",  SbeCount, 0);
      check("rst_dbecount",  DbeCount, 0);
      check("rst_in_ready",  In_ready, 1);

      // Single words through the table, two edges to Out_valid.
      exp_sc = 0; exp_dc = 0;
      for (int i = 0; i < 10; i++) begin
         send_one(vt[i].din, vt[i].chk);
         check({vt[i].name, "_valid"}, Out_valid, 1);
         check({vt[i].name, "_data"},  DataOut, vt[i].dout);
         check({vt[i].name, "_sbe"},   Sbe, vt[i].sbe);
         check({vt[i].name, "_dbe"},   Dbe, vt[i].dbe);
         @(posedge Clock); #1;
         exp_sc += int'(vt[i].sbe);
         exp_dc += int'(vt[i].dbe);
         check({vt[i].name, "_sbecnt"}, SbeCount, exp_sc);
         check({vt[i].name, "_dbecnt"}, DbeCount, exp_dc);
         check({vt[i].name, "_drained"}, Out_valid, 0);
      end

      // Backpressure: 4 words, 5-cycle stall after the first delivery.
      for (int k = 0; k < 4; k++) w[k] = 32'hA5000000 + k;
      tx = 0; rx = 0; stall_left = 0; started = 0;
      Out_ready = 1'b1; In_valid = 1'b1; DataIn = w[0]; ChkIn = tb_enc(w[0]);
      for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
         @(negedge Clock);
         in_hs  = In_valid && In_ready;
         out_hs = Out_valid && Out_ready;
         if (Out_valid) begin
            if (rx < 4) check("bp_order", DataOut, w[rx]);
            else        check("bp_extra_word", Out_valid, 0);
            check("bp_flags", {Sbe, Dbe}, 0);
         end
         if (!Out_ready) begin
            check("bp_hold_valid", Out_valid, 1);
            check("bp_in_ready",   In_ready, 0);
         end
         @(posedge Clock); #1;
         tx += int'(in_hs);
         rx += int'(out_hs);
         if (rx == 1 && !started) begin
            started    = 1;
            stall_left = 5;
         end
         Out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         In_valid = (tx < 4);
         if (tx < 4) begin
            DataIn = w[tx];
            ChkIn  = tb_enc(w[tx]);
         end
      end
      In_valid = 1'b0; Out_ready = 1'b1;
      check("bp_rx_count", rx, 4);
      check("bp_tx_count", tx, 4);
      @(posedge Clock); #1;
      check("bp_no_dup", Out_valid, 0);
      check("bp_sbecnt", SbeCount, exp_sc);

      // Saturation: clear, then 65535 single errors, then one more.
      Cnt_clr = 1'b1;
      @(posedge Clock); #1 Cnt_clr = 1'b0;
      check("clr_sbecnt", SbeCount, 0);
      check("clr_dbecnt", DbeCount, 0);
      In_valid = 1'b1; DataIn = 32'h1; ChkIn = 7'h00;
      repeat (65535) @(posedge Clock);
      #1 In_valid = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      check("sat_reach_max", SbeCount, 16'hFFFF);
      check("sat_dbe_zero",  DbeCount, 0);
      send_one(32'h1, 7'h00);
      check("sat_extra_sbe", Sbe, 1);
      @(posedge Clock); #1;
      check("sat_no_wrap", SbeCount, 16'hFFFF);

      // Clear coincident with an error handshake.
      send_one(32'h1, 7'h00);
      check("clrhs_valid", Out_valid, 1);
      check("clrhs_sbe",   Sbe, 1);
      Cnt_clr = 1'b1;
      @(posedge Clock); #1 Cnt_clr = 1'b0;
      check("clrhs_sbecnt", SbeCount, 0);
      send_one(32'h3, 7'h00);
      check("post_clr_dbe", Dbe, 1);
      @(posedge Clock); #1;
      check("post_clr_dbecnt", DbeCount, 1);
      check("post_clr_sbecnt", SbeCount, 0);

      // Reset with both stages full.
      Out_ready = 1'b0; In_valid = 1'b1; DataIn = 32'h1; ChkIn = 7'h00;
      @(posedge Clock); #1 DataIn = 32'h2;
      @(posedge Clock); #1 In_valid = 1'b0;
      check("full_valid",    Out_valid, 1);
      check("full_in_ready", In_ready, 0);
      Reset = 1'b1;
      @(posedge Clock); #1 Reset = 1'b0;
      check("midrst_valid",    Out_valid, 0);
      check("midrst_sbe",      Sbe, 0);
      check("midrst_dataout",  DataOut, 0);
      check("midrst_counts",   {SbeCount, DbeCount}, 0);
      check("midrst_in_ready", In_ready, 1);
      Out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge Clock); #1;
         check("midrst_no_output", Out_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
